// File: rtl/aidan_mcnay_prime_pkg.sv
// rtl/aidan_mcnay_prime_pkg.sv - shared width constant and FSM encoding for the trial-division prime checker
package aidan_mcnay_prime_pkg;

    localparam int NBITS_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } trial_div_state_e;

endpackage

// File: rtl/aidan_mcnay_trial_div_dpath.sv
// rtl/aidan_mcnay_trial_div_dpath.sv - candidate/divisor registers, multiply-compare and result registers
module aidan_mcnay_trial_div_dpath
    import aidan_mcnay_prime_pkg::*;
#(
    parameter int nbits = NBITS_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [nbits-1:0] number,
    input  logic             load_n,
    input  logic             incr_d,
    input  logic             set_prime,
    input  logic             set_factor,
    input  logic [nbits-1:0] div_result,
    output logic             number_lt2,
    output logic             q_lt_d,
    output logic             prod_eq_n,
    output logic [nbits-1:0] div_opa,
    output logic [nbits-1:0] div_opb,
    output logic             is_prime,
    output logic [nbits-1:0] factor
);

    localparam logic [nbits-1:0] TWO = nbits'(2);
    localparam logic [nbits-1:0] ONE = nbits'(1);

    logic [nbits-1:0] n_reg;
    logic [nbits-1:0] d_reg;
    logic [nbits-1:0] prod;

    // q = floor(N/d) so q*d <= N always fits in nbits
    assign prod       = div_result * d_reg;
    assign number_lt2 = number < TWO;
    assign q_lt_d     = div_result < d_reg;
    assign prod_eq_n  = prod == n_reg;

    assign div_opa = n_reg;
    assign div_opb = d_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            n_reg    <= '0;
            d_reg    <= '0;
            is_prime <= 1'b0;
            factor   <= '0;
        end else begin
            if (load_n) begin
                n_reg    <= number;
                d_reg    <= TWO;
                is_prime <= 1'b0;
                factor   <= '0;
            end
            if (incr_d) begin
                d_reg <= d_reg + ONE;
            end
            if (set_prime) begin
                is_prime <= 1'b1;
                factor   <= '0;
            end
            if (set_factor) begin
                is_prime <= 1'b0;
                factor   <= d_reg;
            end
        end
    end

endmodule

// File: rtl/aidan_mcnay_trial_div_ctrl.sv
// rtl/aidan_mcnay_trial_div_ctrl.sv - trial-division primality controller driving an external divider
module aidan_mcnay_trial_div_ctrl
    import aidan_mcnay_prime_pkg::*;
#(
    parameter int nbits = NBITS_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [nbits-1:0] number,
    input  logic             req_val,
    output logic             req_rdy,
    output logic             is_prime,
    output logic [nbits-1:0] factor,
    output logic             resp_val,
    input  logic             resp_rdy,
    output logic [nbits-1:0] div_opa,
    output logic [nbits-1:0] div_opb,
    output logic             div_istream_val,
    input  logic             div_istream_rdy,
    input  logic [nbits-1:0] div_result,
    input  logic             div_ostream_val,
    output logic             div_ostream_rdy
);

    trial_div_state_e state_q;
    trial_div_state_e state_d;

    logic load_n;
    logic incr_d;
    logic set_prime;
    logic set_factor;
    logic number_lt2;
    logic q_lt_d;
    logic prod_eq_n;

    aidan_mcnay_trial_div_dpath #(
        .nbits(nbits)
    ) u_dpath (
        .clk        (clk),
        .reset      (reset),
        .number     (number),
        .load_n     (load_n),
        .incr_d     (incr_d),
        .set_prime  (set_prime),
        .set_factor (set_factor),
        .div_result (div_result),
        .number_lt2 (number_lt2),
        .q_lt_d     (q_lt_d),
        .prod_eq_n  (prod_eq_n),
        .div_opa    (div_opa),
        .div_opb    (div_opb),
        .is_prime   (is_prime),
        .factor     (factor)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        req_rdy         = 1'b0;
        resp_val        = 1'b0;
        div_istream_val = 1'b0;
        div_ostream_rdy = 1'b0;
        load_n          = 1'b0;
        incr_d          = 1'b0;
        set_prime       = 1'b0;
        set_factor      = 1'b0;
        case (state_q)
            IDLE: begin
                req_rdy = 1'b1;
                if (req_val) begin
                    load_n  = 1'b1;
                    // 0 and 1 are neither prime nor composite: answer without the divider
                    state_d = number_lt2 ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                div_istream_val = 1'b1;
                if (div_istream_rdy) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                div_ostream_rdy = 1'b1;
                if (div_ostream_val) begin
                    if (q_lt_d) begin
                        set_prime = 1'b1;
                        state_d   = DONE;
                    end else if (prod_eq_n) begin
                        set_factor = 1'b1;
                        state_d    = DONE;
                    end else begin
                        incr_d  = 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            DONE: begin
                resp_val = 1'b1;
                if (resp_rdy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_aidan_mcnay_trial_div_ctrl.sv
// tb/tb_aidan_mcnay_trial_div_ctrl.sv - scoreboard bench with a behavioural divider for the trial-division controller
module tb_aidan_mcnay_trial_div_ctrl;

    localparam int NB = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [NB-1:0] number;
    logic          req_val;
    logic          req_rdy;
    logic          is_prime;
    logic [NB-1:0] factor;
    logic          resp_val;
    logic          resp_rdy;
    logic [NB-1:0] div_opa;
    logic [NB-1:0] div_opb;
    logic          div_istream_val;
    logic          div_istream_rdy;
    logic [NB-1:0] div_result;
    logic          div_ostream_val;
    logic          div_ostream_rdy;

    always #5 clk = ~clk;

    aidan_mcnay_trial_div_ctrl #(
        .nbits(NB)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .number          (number),
        .req_val         (req_val),
        .req_rdy         (req_rdy),
        .is_prime        (is_prime),
        .factor          (factor),
        .resp_val        (resp_val),
        .resp_rdy        (resp_rdy),
        .div_opa         (div_opa),
        .div_opb         (div_opb),
        .div_istream_val (div_istream_val),
        .div_istream_rdy (div_istream_rdy),
        .div_result      (div_result),
        .div_ostream_val (div_ostream_val),
        .div_ostream_rdy (div_ostream_rdy)
    );

    typedef struct {
        logic          prime;
        logic [NB-1:0] fac;
        int            txn;
        int            lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   cyc        = 0;
    int   txn        = 0;
    int   accept_cyc = 0;
    bit   stall_en   = 1'b0;
    int   resp_hold  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {req_rdy, resp_val, is_prime, factor, div_istream_val, div_ostream_rdy, div_opa, div_opb},
              {1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0});
    endtask

    // Behavioural divider: inputs driven at negedge, handshakes resolved for the following posedge
    initial begin
        bit            pend = 1'b0;
        int            lat = 0;
        logic [NB-1:0] res = '0;
        bit            iss_stall = 1'b0;
        logic [NB-1:0] s_opa = '0;
        logic [NB-1:0] s_opb = '0;
        div_istream_rdy = 1'b0;
        div_ostream_val = 1'b0;
        div_result      = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pend = 1'b0;
                iss_stall = 1'b0;
                div_ostream_val = 1'b0;
                div_istream_rdy = 1'b0;
                continue;
            end
            if (req_val && req_rdy) begin
                txn = 0;
                accept_cyc = cyc;
            end
            if (iss_stall) begin
                check("istream_val_held", div_istream_val, 1'b1);
                check("opa_stable", div_opa, s_opa);
                check("opb_stable", div_opb, s_opb);
            end
            if (pend) begin
                if (lat > 0) lat--;
                div_ostream_val = (lat == 0);
                div_result = res;
            end else begin
                div_ostream_val = 1'b0;
            end
            div_istream_rdy = stall_en ? ($urandom_range(0, 2) == 0) : 1'b1;
            if (div_ostream_val && div_ostream_rdy) pend = 1'b0;
            iss_stall = div_istream_val && !div_istream_rdy;
            s_opa = div_opa;
            s_opb = div_opb;
            if (div_istream_val && div_istream_rdy) begin
                check("one_outstanding", pend, 1'b0);
                check("divisor_seq", div_opb, txn + 2);
                txn++;
                res  = div_opa / div_opb;
                pend = 1'b1;
                lat  = stall_en ? $urandom_range(0, 3) : 0;
            end
        end
    end

    initial begin
        resp_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (resp_val && resp_hold > 0) begin
                resp_rdy = 1'b0;
                resp_hold--;
            end else begin
                resp_rdy = 1'b1;
            end
        end
    end

    // Monitor: compares each consumed response with the oldest scoreboard entry
    initial begin
        bit            stalled = 1'b0;
        bit            prev_val = 1'b0;
        logic          p_hold = 1'b0;
        logic [NB-1:0] f_hold = '0;
        exp_t          e;
        forever begin
            @(negedge clk);
            if (reset) begin
                stalled = 1'b0;
                prev_val = 1'b0;
                continue;
            end
            if (resp_val) begin
                if (stalled) begin
                    check("resp_prime_stable", is_prime, p_hold);
                    check("resp_factor_stable", factor, f_hold);
                end
                if (!prev_val && sb_q.size() > 0 && sb_q[0].lat >= 0)
                    check("resp_latency", cyc - accept_cyc, sb_q[0].lat);
                if (resp_rdy) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_resp", 1'b1, 1'b0);
                    end else begin
                        e = sb_q.pop_front();
                        check("is_prime", is_prime, e.prime);
                        check("factor", factor, e.fac);
                        check("div_txn_count", txn, e.txn);
                    end
                end
                stalled = !resp_rdy;
                p_hold = is_prime;
                f_hold = factor;
            end else begin
                stalled = 1'b0;
            end
            prev_val = resp_val;
        end
    end

    task automatic send(input logic [NB-1:0] n, input bit push, input logic p, input logic [NB-1:0] f,
                        input int t, input int l, input int hold);
        int   budget = 0;
        exp_t e;
        @(posedge clk);
        #1;
        while (!req_rdy && budget < 5000) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (!req_rdy) begin
            check("req_rdy_timeout", 1'b0, 1'b1);
            return;
        end
        if (push) begin
            e.prime = p;
            e.fac   = f;
            e.txn   = t;
            e.lat   = l;
            sb_q.push_back(e);
        end
        resp_hold = hold;
        number  = n;
        req_val = 1'b1;
        @(posedge clk);
        #1;
        req_val = 1'b0;
        number  = '0;
    endtask

    initial begin
        int budget;
        reset   = 1'b1;
        req_val = 1'b0;
        number  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_outputs");
        reset = 1'b0;

        send(16'd0,     1, 1'b0, 16'd0, 0,   1,  0);
        send(16'd1,     1, 1'b0, 16'd0, 0,   1,  0);
        send(16'd2,     1, 1'b1, 16'd0, 1,   -1, 0);
        send(16'd91,    1, 1'b0, 16'd7, 6,   -1, 0);
        send(16'd65535, 1, 1'b0, 16'd3, 2,   -1, 0);
        send(16'd65521, 1, 1'b1, 16'd0, 255, -1, 0);
        send(16'd4,     1, 1'b0, 16'd2, 1,   -1, 0);
        send(16'd9,     1, 1'b0, 16'd3, 2,   -1, 0);
        send(16'd3,     1, 1'b1, 16'd0, 1,   -1, 0);

        stall_en = 1'b1;
        send(16'd91,    1, 1'b0, 16'd7, 6,   -1, 5);
        send(16'd65535, 1, 1'b0, 16'd3, 2,   -1, 5);
        send(16'd1,     1, 1'b0, 16'd0, 0,   1,  5);
        send(16'd13,    1, 1'b1, 16'd0, 3,   -1, 5);
        stall_en = 1'b0;

        send(16'd91, 0, 1'b0, 16'd0, 0, -1, 0);
        budget = 0;
        while (!(txn == 3 && div_ostream_rdy) && budget < 2000) begin
            @(posedge clk);
            #1;
            budget++;
        end
        check("reach_wait_for_reset", div_ostream_rdy, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("midop_reset_outputs");
        reset = 1'b0;
        send(16'd13, 1, 1'b1, 16'd0, 3, -1, 0);

        budget = 0;
        while ((sb_q.size() != 0 || !req_rdy) && budget < 10000) begin
            @(posedge clk);
            #1;
            budget++;
        end
        check("drain_scoreboard", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aidan_mcnay_trial_div_ctrl.md
AIDAN_MCNAY_TRIAL_DIV_CTRL -- requirements
Module: aidan_mcnay_trial_div_ctrl

Interface
REQ-001 SHALL have parameter: nbits, default 16, width of candidate, divisor, quotient and factor.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: number  input  nbits  candidate N; sampled on req handshake.
REQ-005 SHALL have port: req_val  input  1  candidate valid.
REQ-006 SHALL have port: req_rdy  output  1  ready for a new candidate.
REQ-007 SHALL have port: is_prime  output  1  1 = N prime.
REQ-008 SHALL have port: factor  output  nbits  smallest factor >1 if composite, else 0.
REQ-009 SHALL have port: resp_val  output  1  is_prime/factor valid.
REQ-010 SHALL have port: resp_rdy  input  1  consumer ready.
REQ-011 SHALL have port: div_opa  output  nbits  dividend to divider (N).
REQ-012 SHALL have port: div_opb  output  nbits  divisor to divider (d).
REQ-013 SHALL have port: div_istream_val  output  1  divider request valid.
REQ-014 SHALL have port: div_istream_rdy  input  1  divider accepts request.
REQ-015 SHALL have port: div_result  input  nbits  quotient floor(opa/opb).
REQ-016 SHALL have port: div_ostream_val  input  1  quotient valid.
REQ-017 SHALL have port: div_ostream_rdy  output  1  controller accepts quotient.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-019 SHALL assert req_rdy only in IDLE; on req_val&req_rdy, register N, set d=2, go to ISSUE, except N<2, which goes directly to DONE with is_prime=0, factor=0 and no divider transaction.
REQ-020 SHALL, in ISSUE, drive div_opa=N, div_opb=d, div_istream_val=1; stay until div_istream_rdy=1, then go to WAIT; opa/opb stable while val high.
REQ-021 SHALL, in WAIT, drive div_ostream_rdy=1 (0 in every other state); on div_ostream_val&div_ostream_rdy, register q=div_result and evaluate in the same cycle.
REQ-022 SHALL evaluate in priority order: q<d -> DONE, is_prime=1, factor=0; else q*d==N -> DONE, is_prime=0, factor=d; else d<=d+1 and return to ISSUE.
REQ-023 SHALL compute q*d in nbits without overflow (q*d <= N by construction); d never wraps since d <= floor(sqrt(N))+1.
REQ-024 SHALL hold resp_val=1 with is_prime/factor stable in DONE until resp_rdy=1, then return to IDLE; next request accepted no earlier than the following cycle.
REQ-025 SHALL ignore div_ostream_val outside WAIT and req_val outside IDLE.
REQ-026 SHALL issue exactly one divider request per divisor tried; never two outstanding.

Reset
REQ-027 SHALL, on reset, enter IDLE and drive req_rdy=1, resp_val=0, is_prime=0, factor=0, div_istream_val=0, div_ostream_rdy=0, div_opa=0, div_opb=0.
REQ-028 SHALL abandon any in-flight candidate on reset mid-operation with no response; the divider shares the same reset.

Structure
REQ-029 SHALL take the FSM state encoding from the shared package aidan_mcnay_prime_pkg, alongside the default width constant (16).
REQ-030 SHALL split into control FSM plus one datapath sub-module, aidan_mcnay_trial_div_dpath (N, d, q registers, multiply-compare); the divider is instantiated by the parent, not inside this block.

Verification
REQ-031 SHALL cover: N=0 and N=1 -> is_prime=0, factor=0, zero divider transactions, resp_val one cycle after accept.
REQ-032 SHALL cover: N=2 -> one transaction (2/2, q=1<2) -> is_prime=1, factor=0.
REQ-033 SHALL cover: N=91 -> divisors 2..7 issued (6 transactions) -> is_prime=0, factor=7; N=65535 -> factor=3.
REQ-034 SHALL cover: N=65521 -> 255 transactions (d=2..256) -> is_prime=1.
REQ-035 SHALL cover backpressure: random div_istream_rdy stalls and resp_rdy held low 5 cycles -> opa/opb/resp outputs stable, results unchanged.
REQ-036 SHALL cover: reset asserted in WAIT during N=91 -> IDLE next cycle, all outputs at reset values, then N=13 -> is_prime=1.
